conv_loop_sequencer: RTL and testbench



---
 rtl/conv_loop_sequencer_pkg.sv | 29 ++
 rtl/conv_loop_sequencer_if.sv | 32 +++
 rtl/conv_loop_sequencer_wrap_counter.sv | 37 +++
 rtl/conv_loop_sequencer.sv | 137 +++++++++++++
 tb/tb_conv_loop_sequencer.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/conv_loop_sequencer_pkg.sv
// Shared state enum, default layer dimensions and index widths for the
// convolution loop-nest sequencer.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    localparam int unsigned DEF_M_OUT  = 6;
    localparam int unsigned DEF_R_OUT  = 28;
    localparam int unsigned DEF_C_OUT  = 28;
    localparam int unsigned DEF_N_IN   = 1;
    localparam int unsigned DEF_N_STEP = 4;
    localparam int unsigned DEF_K      = 5;

    localparam int unsigned IDX_W  = 8;
    localparam int unsigned KIDX_W = 4;

    // Largest multiple of step strictly below n.
    function automatic int unsigned last_step(
        input int unsigned n,
        input int unsigned step
    );
        return ((n - 1) / step) * step;
    endfunction

endpackage

// File: rtl/conv_loop_sequencer_if.sv
// Control and index bundle between the loop sequencer and the address
// controller; master is the sequencer side.
interface conv_seq_if;
    import conv_pkg::*;

    logic              start;
    logic              hold;
    logic [IDX_W-1:0]  m;
    logic [IDX_W-1:0]  r;
    logic [IDX_W-1:0]  c;
    logic [IDX_W-1:0]  n;
    logic [KIDX_W-1:0] i;
    logic [KIDX_W-1:0] j;
    logic              valid;
    logic              first_tap;
    logic              last_tap;
    logic              busy;
    logic              done;

    modport master (
        input  start, hold,
        output m, r, c, n, i, j,
        output valid, first_tap, last_tap, busy, done
    );

    modport slave (
        output start, hold,
        input  m, r, c, n, i, j,
        input  valid, first_tap, last_tap, busy, done
    );

endinterface

// File: rtl/conv_loop_sequencer_wrap_counter.sv
// One loop level: steps by STEP when enabled and carried into, wraps to 0
// after MAX and raises carry_out to the next level.
module wrap_counter #(
    parameter int unsigned W    = 8,
    parameter int unsigned MAX  = 0,
    parameter int unsigned STEP = 1
) (
    input  logic         clock,
    input  logic         en,
    input  logic         carry_in,
    input  logic         clear,
    output logic [W-1:0] value,
    output logic         carry_out
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;
    logic         at_max;

    assign at_max    = (value_q == W'(MAX));
    assign carry_out = carry_in & at_max;
    assign value     = value_q;

    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = '0;
        end else if (en && carry_in) begin
            value_d = at_max ? '0 : value_q + W'(STEP);
        end
    end

    always_ff @(posedge clock) begin
        value_q <= value_d;
    end

endmodule

// File: rtl/conv_loop_sequencer.sv
// Walks the (m,r,c,n,i,j) loop nest of one conv layer, one tuple per cycle.
// Define CONV_SEQ_STALL_EN to honour the downstream hold input.
module conv_loop_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned M_OUT  = DEF_M_OUT,
    parameter int unsigned R_OUT  = DEF_R_OUT,
    parameter int unsigned C_OUT  = DEF_C_OUT,
    parameter int unsigned N_IN   = DEF_N_IN,
    parameter int unsigned N_STEP = DEF_N_STEP,
    parameter int unsigned K      = DEF_K
) (
    input  logic      clock,
    input  logic      resetn,
    conv_seq_if.master sif
);

    localparam int unsigned N_LAST = last_step(N_IN, N_STEP);

    if (M_OUT < 1 || M_OUT > 255 || R_OUT < 1 || R_OUT > 255 ||
        C_OUT < 1 || C_OUT > 255 || N_IN < 1 || N_IN > 255 ||
        N_STEP < 1 || N_STEP > 255 || K < 1 || K > 15) begin : g_bad_params
        $error("conv_loop_sequencer: layer dimensions out of range");
    end

    seq_state_e state_q;
    logic       valid_q;
    logic       busy_q;
    logic       done_q;

    logic       adv;
    logic       clr;
    logic [5:0] cy;

    logic [IDX_W-1:0]  m_v;
    logic [IDX_W-1:0]  r_v;
    logic [IDX_W-1:0]  c_v;
    logic [IDX_W-1:0]  n_v;
    logic [KIDX_W-1:0] i_v;
    logic [KIDX_W-1:0] j_v;

`ifdef CONV_SEQ_STALL_EN
    assign adv = (state_q == ST_RUN) & ~sif.hold;
`else
    logic unused_hold;
    assign unused_hold = sif.hold;
    assign adv = (state_q == ST_RUN);
`endif

    // Counters sit at zero outside RUN so every layer starts from the origin.
    assign clr = ~resetn | (state_q != ST_RUN);

    wrap_counter #(.W(KIDX_W), .MAX(K - 1), .STEP(1)) u_j (
        .clock(clock), .en(adv), .carry_in(1'b1), .clear(clr),
        .value(j_v), .carry_out(cy[0])
    );

    wrap_counter #(.W(KIDX_W), .MAX(K - 1), .STEP(1)) u_i (
        .clock(clock), .en(adv), .carry_in(cy[0]), .clear(clr),
        .value(i_v), .carry_out(cy[1])
    );

    wrap_counter #(.W(IDX_W), .MAX(N_LAST), .STEP(N_STEP)) u_n (
        .clock(clock), .en(adv), .carry_in(cy[1]), .clear(clr),
        .value(n_v), .carry_out(cy[2])
    );

    wrap_counter #(.W(IDX_W), .MAX(C_OUT - 1), .STEP(1)) u_c (
        .clock(clock), .en(adv), .carry_in(cy[2]), .clear(clr),
        .value(c_v), .carry_out(cy[3])
    );

    wrap_counter #(.W(IDX_W), .MAX(R_OUT - 1), .STEP(1)) u_r (
        .clock(clock), .en(adv), .carry_in(cy[3]), .clear(clr),
        .value(r_v), .carry_out(cy[4])
    );

    wrap_counter #(.W(IDX_W), .MAX(M_OUT - 1), .STEP(1)) u_m (
        .clock(clock), .en(adv), .carry_in(cy[4]), .clear(clr),
        .value(m_v), .carry_out(cy[5])
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (sif.start) begin
                        state_q <= ST_RUN;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Full carry out of m marks the final tuple.
                    if (adv && cy[5]) begin
                        state_q <= ST_DONE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sif.m     = m_v;
    assign sif.r     = r_v;
    assign sif.c     = c_v;
    assign sif.n     = n_v;
    assign sif.i     = i_v;
    assign sif.j     = j_v;
    assign sif.valid = valid_q;
    assign sif.busy  = busy_q;
    assign sif.done  = done_q;

    assign sif.first_tap = valid_q && (n_v == '0) &&
                           (i_v == '0) && (j_v == '0);
    assign sif.last_tap  = valid_q && (n_v == IDX_W'(N_LAST)) &&
                           (i_v == KIDX_W'(K - 1)) &&
                           (j_v == KIDX_W'(K - 1));

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Bench for conv_loop_sequencer: a nested-loop tuple list plus a simple
// cycle model drives per-cycle checks under random start/hold/reset.
module tb_conv_loop_sequencer;
    import conv_pkg::*;

    localparam int unsigned TM = 2;
    localparam int unsigned TR = 3;
    localparam int unsigned TC = 2;
    localparam int unsigned TN = 6;
    localparam int unsigned TS = 4;
    localparam int unsigned TK = 2;
    localparam int unsigned NSTEPS = (TN + TS - 1) / TS;
    localparam int unsigned LEN = TM * TR * TC * NSTEPS * TK * TK;
    localparam int unsigned PIX = TM * TR * TC;

`ifdef CONV_SEQ_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    logic clock = 1'b0;
    logic resetn = 1'b0;

    conv_seq_if sif();

    conv_loop_sequencer #(
        .M_OUT(TM), .R_OUT(TR), .C_OUT(TC),
        .N_IN(TN), .N_STEP(TS), .K(TK)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .sif(sif)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [39:0] t;
        bit          f;
        bit          l;
    } ent_t;

    ent_t ref_q[$];

    logic [39:0] tup;
    assign tup = {sif.m, sif.r, sif.c, sif.n, sif.i, sif.j};

    int errors = 0;
    int checks = 0;
    int ms = 0;
    int p = 0;
    int firsts, lasts, dones, vcyc, holds;

    task automatic chk(input string tag, input logic [39:0] obs,
                       input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit st, hd, rs, adv;
        bit ev, ed, ef, el;
        logic [39:0] et;
        st = sif.start;
        hd = sif.hold;
        rs = resetn;
        if (rs && ms == 1 && hd) holds++;
        @(posedge clock);
        if (!rs) begin
            ms = 0;
            p = 0;
        end else begin
            case (ms)
                0: if (st) begin ms = 1; p = 0; end
                1: begin
                    adv = STALL ? !hd : 1'b1;
                    if (adv) begin
                        if (p == int'(LEN) - 1) ms = 2;
                        else p++;
                    end
                end
                default: ms = 0;
            endcase
        end
        #1;
        ev = (ms == 1);
        ed = (ms == 2);
        et = ev ? ref_q[p].t : '0;
        ef = ev && ref_q[p].f;
        el = ev && ref_q[p].l;
        chk("tuple", tup, et);
        chk("valid", 40'(sif.valid), 40'(ev));
        chk("busy", 40'(sif.busy), 40'(ev));
        chk("done", 40'(sif.done), 40'(ed));
        chk("first_tap", 40'(sif.first_tap), 40'(ef));
        chk("last_tap", 40'(sif.last_tap), 40'(el));
        firsts += int'(sif.first_tap);
        lasts  += int'(sif.last_tap);
        dones  += int'(sif.done);
        vcyc   += int'(sif.valid);
    endtask

    task automatic run_layer(input bit rand_hold, input int abort_at);
        int cyc;
        firsts = 0; lasts = 0; dones = 0; vcyc = 0; holds = 0;
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        chk("first_tuple_zero", tup, 40'h0);
        cyc = 0;
        while (ms != 0 && cyc < 4 * int'(LEN)) begin
            if (abort_at >= 0 && cyc == abort_at) resetn = 1'b0;
            sif.hold  = rand_hold && ($urandom_range(0, 3) == 0);
            sif.start = (ms == 2) || ($urandom_range(0, 7) == 0);
            tick();
            resetn = 1'b1;
            cyc++;
        end
        sif.start = 1'b0;
        sif.hold  = 1'b0;
        chk("cycle_budget", 40'(cyc < 4 * int'(LEN)), 40'h1);
        if (abort_at >= 0) begin
            chk("abort_no_done", 40'(dones), 40'h0);
        end else begin
            chk("done_count", 40'(dones), 40'h1);
            chk("first_count", 40'(firsts), 40'(PIX));
            chk("last_count", 40'(lasts), 40'(PIX));
            chk("layer_len", 40'(vcyc),
                40'(int'(LEN) + (STALL ? holds : 0)));
        end
        repeat (3) tick();
    endtask

    initial begin
        ent_t e;
        for (int mm = 0; mm < int'(TM); mm++)
            for (int rr = 0; rr < int'(TR); rr++)
                for (int cc = 0; cc < int'(TC); cc++)
                    for (int nn = 0; nn < int'(TN); nn += int'(TS))
                        for (int ii = 0; ii < int'(TK); ii++)
                            for (int jj = 0; jj < int'(TK); jj++) begin
                                e.t = {8'(mm), 8'(rr), 8'(cc), 8'(nn),
                                       4'(ii), 4'(jj)};
                                e.f = (nn == 0) && (ii == 0) && (jj == 0);
                                e.l = (nn + int'(TS) >= int'(TN)) &&
                                      (ii == int'(TK) - 1) &&
                                      (jj == int'(TK) - 1);
                                ref_q.push_back(e);
                            end

        sif.start = 1'b0;
        sif.hold  = 1'b0;
        resetn    = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        tick();

        run_layer(1'b0, -1);
        run_layer(1'b1, -1);
        run_layer(1'b1, int'($urandom_range(10, LEN - 10)));
        run_layer(1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
